l1_miss_ctrl: RTL and testbench
===============================

L1_MISS_CTRL -- requirements
Module: l1_miss_ctrl

Interface
REQ-001 SHALL have parameter AW, default 32, meaning the core and next-level address width.
REQ-002 SHALL have parameter DW, default 64, meaning the data word width.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port core_req  in  1  request strobe, held by the core until core_done.
REQ-006 SHALL have ports core_we  in  1  (1 = write) and core_addr  in  AW  (word address).
REQ-007 SHALL have ports core_wdata  in  DW  and core_rdata  out  DW  (read result).
REQ-008 SHALL have port core_done  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports l1_mode  out  2 (00 read, 11 write, 01 idle) and l1_st  out  AW (cache address).
REQ-010 SHALL have ports l1_in  out  DW, l1_out  in  DW and l1_ch  in  1 (1 = miss).
REQ-011 SHALL have ports mem_req  out  1, mem_addr  out  AW (line-aligned), mem_rdata  in  DW, mem_valid  in  1 (one beat).

Function
REQ-012 SHALL decode addresses as word = addr[3:0], index = addr[10:4], tag = addr[13:11].
REQ-013 SHALL implement the states IDLE, LOOKUP, REFILL, WRITE and RESP.
REQ-014 SHALL, in IDLE with core_req=1, latch addr/we/wdata, drive l1_mode=00 and l1_st=addr, and go to LOOKUP.
REQ-015 SHALL sample l1_ch only in LOOKUP; it SHALL ignore l1_ch in all other states.
REQ-016 SHALL, in LOOKUP with l1_ch=0 and a read, register core_rdata<=l1_out and go to RESP (read-hit latency: core_done 2 edges after core_req is sampled).
REQ-017 SHALL, in LOOKUP with l1_ch=0 and a write, go to WRITE and drive l1_mode=11, l1_st=addr and l1_in=wdata for exactly one cycle, then go to RESP.
REQ-018 SHALL, in LOOKUP with l1_ch=1, clear the 4-bit beat counter, assert mem_req, drive mem_addr={addr[AW-1:4],4'b0} and go to REFILL.
REQ-019 SHALL, in REFILL on each cycle with mem_valid=1, drive l1_mode=11, l1_st={addr[AW-1:4],beat} and l1_in=mem_rdata, and increment beat.
REQ-020 SHALL, in REFILL on cycles with mem_valid=0, drive l1_mode=01 so that no spurious cache write occurs.
REQ-021 SHALL, on the 16th beat (beat=15), deassert mem_req on the following edge and return to LOOKUP with a read probe, which then hits.
REQ-022 SHALL ignore mem_valid outside REFILL, and SHALL ignore core_req outside IDLE.
REQ-023 SHALL, in RESP, pulse core_done for one cycle, drive l1_mode=01 and return to IDLE; a core_req still high in the next IDLE cycle SHALL be treated as a new request.
REQ-024 SHALL hold core_rdata stable from RESP until the next read completes.

Reset
REQ-025 SHALL, on rst=1 asynchronously, set state=IDLE, beat=0, mem_req=0, core_done=0, core_rdata=0, l1_mode=01, l1_st=0, l1_in=0 and mem_addr=0.
REQ-026 SHALL, on reset mid-REFILL, abandon the fill without replay; the partially filled line remains tag-valid, and this is a documented limitation.

Configuration
REQ-027 SHALL, when L1_MISS_CTRL_STATS_EN is defined, add outputs hit_cnt and miss_cnt (16 bits each), incremented once per LOOKUP decision, saturating at 16'hFFFF, and cleared by rst; a post-refill re-probe SHALL NOT be counted.
REQ-028 SHALL, when L1_MISS_CTRL_STATS_EN is not defined, omit hit_cnt and miss_cnt and their logic entirely.

Structure
REQ-029 SHALL place the state encoding, the MODE_READ/MODE_WRITE/MODE_IDLE constants, LINE_WORDS=16 and the field bit positions in the shared package l1_miss_pkg.
REQ-030 SHALL implement the optional counters in the sub-module l1_miss_stats, instantiated only under L1_MISS_CTRL_STATS_EN.

Verification
REQ-031 SHALL cover a read hit: preload the line at addr 0x11, then read 0x11 -> core_rdata matches the stored word, core_done 2 edges after req, mem_req stays 0.
REQ-032 SHALL cover a read miss: read 0x2340 with memory returning 0xA0..0xAF -> 16 L1 writes to l1_st 0x2340..0x234F, then core_rdata=0xA0.
REQ-033 SHALL cover a write miss: write 0x5555 to 0x0813 -> line refilled, one write with l1_in=0x5555, and a subsequent read of 0x0813 returns 0x5555.
REQ-034 SHALL cover gapped mem_valid (alternating 1/0) -> exactly 16 writes, l1_mode=01 on every gap cycle, correct data.
REQ-035 SHALL cover rst asserted at beat 7 -> mem_req=0 immediately and state IDLE, and the next request is served normally.
REQ-036 SHALL cover, with STATS_EN, one hit then one miss -> hit_cnt=1 and miss_cnt=1.

Source files
------------

// File: rtl/l1_miss_pkg.sv
// Shared definitions for the L1 miss controller: FSM encoding, L1 port modes,
// line geometry and address field positions.
package l1_miss_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_WRITE,
    ST_RESP
  } state_e;

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b11;
  localparam logic [1:0] MODE_IDLE  = 2'b01;

  localparam int LINE_WORDS = 16;
  localparam int BEAT_W     = 4;
  localparam logic [BEAT_W-1:0] LAST_BEAT = 4'(LINE_WORDS - 1);

  localparam int WORD_LSB  = 0;
  localparam int WORD_MSB  = 3;
  localparam int INDEX_LSB = 4;
  localparam int INDEX_MSB = 10;
  localparam int TAG_LSB   = 11;
  localparam int TAG_MSB   = 13;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/l1_miss_stats.sv
// Saturating hit/miss counters for the L1 miss controller; only instantiated
// when L1_MISS_CTRL_STATS_EN is defined.
module l1_miss_stats
  import l1_miss_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hit_evt,
  input  logic        miss_evt,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_evt  ? sat_inc(hit_cnt_q)  : hit_cnt_q;
    miss_cnt_d = miss_evt ? sat_inc(miss_cnt_q) : miss_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: rtl/l1_miss_ctrl.sv
// L1 miss controller: probes the cache, refills a 16-word line on a miss and
// completes core reads/writes. Optional hit/miss counters: L1_MISS_CTRL_STATS_EN.
module l1_miss_ctrl
  import l1_miss_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_done,
  output logic [1:0]    l1_mode,
  output logic [AW-1:0] l1_st,
  output logic [DW-1:0] l1_in,
  input  logic [DW-1:0] l1_out,
  input  logic          l1_ch,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid
`ifdef L1_MISS_CTRL_STATS_EN
  ,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
`endif
);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                fill_done_q, fill_done_d;
  logic                mem_req_q, mem_req_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic                core_done_q, core_done_d;
  logic [DW-1:0]       core_rdata_q, core_rdata_d;
  logic [1:0]          l1_mode_q, l1_mode_d;
  logic [AW-1:0]       l1_st_q, l1_st_d;
  logic [DW-1:0]       l1_in_q, l1_in_d;

  logic [AW-1:0]       addr_q;
  logic                we_q;
  logic [DW-1:0]       wdata_q;
  logic                lat_en;
  logic [AW-1:0]       line_addr;

  assign line_addr = {addr_q[AW-1:BEAT_W], {BEAT_W{1'b0}}};

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    fill_done_d  = fill_done_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    core_done_d  = 1'b0;
    core_rdata_d = core_rdata_q;
    l1_mode_d    = l1_mode_q;
    l1_st_d      = l1_st_q;
    l1_in_d      = l1_in_q;
    lat_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        l1_mode_d = MODE_IDLE;
        if (core_req) begin
          lat_en    = 1'b1;
          l1_mode_d = MODE_READ;
          l1_st_d   = core_addr;
          state_d   = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (l1_ch) begin
          beat_d      = '0;
          fill_done_d = 1'b0;
          mem_req_d   = 1'b1;
          mem_addr_d  = line_addr;
          l1_mode_d   = MODE_IDLE;
          state_d     = ST_REFILL;
        end else if (we_q) begin
          l1_mode_d = MODE_WRITE;
          l1_st_d   = addr_q;
          l1_in_d   = wdata_q;
          state_d   = ST_WRITE;
        end else begin
          core_rdata_d = l1_out;
          core_done_d  = 1'b1;
          l1_mode_d    = MODE_IDLE;
          state_d      = ST_RESP;
        end
      end
      ST_REFILL: begin
        // One spare cycle after the last beat lets its L1 write land before the re-probe.
        if (fill_done_q) begin
          mem_req_d = 1'b0;
          l1_mode_d = MODE_READ;
          l1_st_d   = addr_q;
          state_d   = ST_LOOKUP;
        end else if (mem_valid) begin
          l1_mode_d   = MODE_WRITE;
          l1_st_d     = {addr_q[AW-1:BEAT_W], beat_q};
          l1_in_d     = mem_rdata;
          beat_d      = beat_q + 1'b1;
          fill_done_d = (beat_q == LAST_BEAT);
        end else begin
          l1_mode_d = MODE_IDLE;
        end
      end
      ST_WRITE: begin
        l1_mode_d   = MODE_IDLE;
        core_done_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        l1_mode_d = MODE_IDLE;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      fill_done_q  <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      core_done_q  <= 1'b0;
      core_rdata_q <= '0;
      l1_mode_q    <= MODE_IDLE;
      l1_st_q      <= '0;
      l1_in_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      fill_done_q  <= fill_done_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      core_done_q  <= core_done_d;
      core_rdata_q <= core_rdata_d;
      l1_mode_q    <= l1_mode_d;
      l1_st_q      <= l1_st_d;
      l1_in_q      <= l1_in_d;
    end
  end

  // Request payload is only captured on acceptance, so it needs no reset.
  always_ff @(posedge clk) begin
    if (lat_en) begin
      addr_q  <= core_addr;
      we_q    <= core_we;
      wdata_q <= core_wdata;
    end
  end

  assign core_rdata = core_rdata_q;
  assign core_done  = core_done_q;
  assign l1_mode    = l1_mode_q;
  assign l1_st      = l1_st_q;
  assign l1_in      = l1_in_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

`ifdef L1_MISS_CTRL_STATS_EN
  // The probe that follows a refill is not a new decision and is excluded.
  logic reprobe_q, reprobe_d;
  logic probe_evt;

  always_comb begin
    reprobe_d = reprobe_q;
    if (state_q == ST_REFILL && fill_done_q) reprobe_d = 1'b1;
    else if (state_q == ST_LOOKUP)           reprobe_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) reprobe_q <= 1'b0;
    else     reprobe_q <= reprobe_d;
  end

  assign probe_evt = (state_q == ST_LOOKUP) && !reprobe_q;

  l1_miss_stats u_stats (
    .clk      (clk),
    .rst      (rst),
    .hit_evt  (probe_evt && !l1_ch),
    .miss_evt (probe_evt && l1_ch),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );
`endif

endmodule

// File: tb/tb_l1_miss_ctrl.sv
// Randomized bench for l1_miss_ctrl: models the L1 array and next-level memory
// and compares against a line-level reference of cache contents.
module tb_l1_miss_ctrl;

  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          core_done;
  logic [1:0]    l1_mode;
  logic [AW-1:0] l1_st;
  logic [DW-1:0] l1_in, l1_out;
  logic          l1_ch;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid;
`ifdef L1_MISS_CTRL_STATS_EN
  logic [15:0]   hit_cnt, miss_cnt;
`endif

  l1_miss_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_done(core_done),
    .l1_mode(l1_mode), .l1_st(l1_st), .l1_in(l1_in), .l1_out(l1_out), .l1_ch(l1_ch),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
`ifdef L1_MISS_CTRL_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h234) return 64'hA0 + 64'(a[3:0]);
    return {a ^ 32'hC0DE_0000, a * 32'h9E37_79B1};
  endfunction

  // L1 array environment (single writer: the posedge monitor below)
  logic [DW-1:0] c_data [0:2047];
  logic [2:0]    c_tag  [0:127];
  logic          c_vld  [0:127];
  logic          real_miss;
  logic          noise;
  always_comb real_miss = !(c_vld[l1_st[10:4]] && (c_tag[l1_st[10:4]] == l1_st[13:11]));
  assign l1_ch  = (l1_mode == 2'b00) ? real_miss : noise;
  assign l1_out = c_data[l1_st[10:0]];

  // Controls written only by the main initial block
  logic        bd_pre = 1'b0, bd_inv = 1'b0;
  logic [6:0]  bd_idx = '0;
  logic [2:0]  bd_tag = '0;
  logic [63:0] bd_data = '0;
  int          txn_id = 0;
  bit          gap_mode = 1'b0;

  // Observations written only by the posedge monitor
  int          seen_id = 0, wr_n = 0, gap_n = 0, gap_bad = 0, beats = 0;
  bit          gap_pending = 1'b0, mreq_seen = 1'b0, env_init = 1'b0;
  logic [31:0] mreq_addr = '0;
  logic [31:0] wr_st [0:31];
  logic [63:0] wr_in [0:31];

  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 128; i++) c_vld[i] = 1'b0;
      for (int i = 0; i < 2048; i++) c_data[i] = '0;
      env_init = 1'b1;
    end
    if (bd_pre) begin
      for (int w = 0; w < 16; w++) c_data[{bd_idx, w[3:0]}] = bd_data + 64'(w);
      c_tag[bd_idx] = bd_tag;
      c_vld[bd_idx] = 1'b1;
    end
    if (bd_inv) c_vld[bd_idx] = 1'b0;
    if (txn_id != seen_id) begin
      seen_id = txn_id; wr_n = 0; gap_n = 0; gap_bad = 0; mreq_seen = 1'b0; mreq_addr = '0;
    end
    if (rst) begin
      beats = 0; gap_pending = 1'b0;
    end else begin
      if (gap_pending) begin
        gap_n++;
        if (l1_mode != 2'b01) gap_bad++;
      end
      if (l1_mode == 2'b11) begin
        if (wr_n < 32) begin wr_st[wr_n] = l1_st; wr_in[wr_n] = l1_in; end
        wr_n++;
        c_data[l1_st[10:0]] = l1_in;
        c_tag[l1_st[10:4]]  = l1_st[13:11];
        c_vld[l1_st[10:4]]  = 1'b1;
      end
      if (mem_req && !mreq_seen) begin mreq_seen = 1'b1; mreq_addr = mem_addr; end
      gap_pending = mem_req && !mem_valid && (beats < 16);
      if (!mem_req) beats = 0;
      else if (mem_valid && beats < 16) beats++;
    end
  end

  // Next-level memory responder; junk valid outside a live fill must be ignored
  bit gap_tog = 1'b0;
  always @(negedge clk) begin
    noise = 1'($urandom_range(0, 1));
    if (mem_req && beats < 16) begin
      if (gap_mode) begin
        mem_valid = gap_tog;
        gap_tog   = ~gap_tog;
      end else begin
        mem_valid = ($urandom_range(0, 3) != 0);
      end
      mem_rdata = mem_word({mem_addr[31:4], 4'(beats)});
    end else begin
      mem_valid = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom};
    end
  end

  // Reference model: which line each index holds, and words written since its fill
  logic        ref_vld [0:127];
  logic [2:0]  ref_tag [0:127];
  logic [63:0] ref_wr [logic [31:0]];
  logic [63:0] last_rdata = '0;
  int          ref_hits = 0, ref_misses = 0;

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                         input string tag);
    int          idx, lat, exp_wr;
    bit          hit, done;
    logic [63:0] exp_rd, ein;
    logic [31:0] est;
    idx = int'(addr[10:4]);
    hit = ref_vld[idx] && (ref_tag[idx] == addr[13:11]);
    if (hit) ref_hits++;
    else begin
      ref_misses++;
      ref_vld[idx] = 1'b1;
      ref_tag[idx] = addr[13:11];
      for (int w = 0; w < 16; w++) ref_wr.delete({addr[31:4], 4'(w)});
    end
    exp_rd = ref_wr.exists(addr) ? ref_wr[addr] : mem_word(addr);
    if (we) ref_wr[addr] = wd;
    exp_wr = (hit ? 0 : 16) + (we ? 1 : 0);
    txn_id++;
    core_we = we; core_addr = addr; core_wdata = wd; core_req = 1'b1;
    lat = 0; done = 1'b0;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
      if (core_done) done = 1'b1;
    end
    core_req = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'd1);
    if (done) begin
      if (hit) chk({tag, "_latency"}, 64'(lat), we ? 64'd3 : 64'd2);
      if (!we) begin
        chk({tag, "_rdata"}, core_rdata, exp_rd);
        last_rdata = exp_rd;
      end else begin
        chk({tag, "_rdata_hold"}, core_rdata, last_rdata);
      end
      chk({tag, "_l1_writes"}, 64'(wr_n), 64'(exp_wr));
      chk({tag, "_mem_req"}, 64'(mreq_seen), 64'(!hit));
      if (!hit) chk({tag, "_mem_addr"}, mreq_addr, {addr[31:4], 4'h0});
      chk({tag, "_gap_mode"}, 64'(gap_bad), 64'd0);
      for (int k = 0; k < exp_wr && k < wr_n && k < 32; k++) begin
        if (!hit && k < 16) begin
          est = {addr[31:4], 4'(k)};
          ein = mem_word(est);
        end else begin
          est = addr;
          ein = wd;
        end
        chk({tag, "_l1_st"}, wr_st[k], est);
        chk({tag, "_l1_in"}, wr_in[k], ein);
      end
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(core_done), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, got %0t required below 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [6:0]  idx_pool [4];
    logic [31:0] a;
    int          wait_n;
    idx_pool[0] = 7'h01; idx_pool[1] = 7'h02; idx_pool[2] = 7'h34; idx_pool[3] = 7'h7F;
    for (int i = 0; i < 128; i++) ref_vld[i] = 1'b0;
    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_core_done", 64'(core_done), 64'd0);
    chk("rst_core_rdata", core_rdata, 64'd0);
    chk("rst_l1_mode", 64'(l1_mode), 64'd1);
    chk("rst_l1_st", 64'(l1_st), 64'd0);
    chk("rst_l1_in", l1_in, 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
`ifdef L1_MISS_CTRL_STATS_EN
    chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
`endif
    rst = 1'b0;

    // Backdoor preload of the line holding 0x11, then a read hit
    bd_idx = 7'h01; bd_tag = 3'd0; bd_data = 64'hD00D_0000_0000_0000; bd_pre = 1'b1;
    @(negedge clk);
    bd_pre = 1'b0;
    ref_vld[1] = 1'b1; ref_tag[1] = 3'd0;
    for (int w = 0; w < 16; w++) ref_wr[32'h10 + 32'(w)] = bd_data + 64'(w);
    run_txn(1'b0, 32'h0000_0011, 64'h0, "read_hit");
    run_txn(1'b0, 32'h0000_2340, 64'h0, "read_miss");
`ifdef L1_MISS_CTRL_STATS_EN
    chk("stats_hit_cnt", 64'(hit_cnt), 64'd1);
    chk("stats_miss_cnt", 64'(miss_cnt), 64'd1);
`endif
    run_txn(1'b1, 32'h0000_0813, 64'h5555, "write_miss");
    run_txn(1'b0, 32'h0000_0813, 64'h0, "read_after_write");
    run_txn(1'b1, 32'h0000_0817, 64'hBEEF_0001, "write_hit");

    gap_mode = 1'b1;
    run_txn(1'b0, 32'h0000_1C70, 64'h0, "gapped");
    chk("gapped_gap_count", 64'(gap_n >= 15), 64'd1);
    gap_mode = 1'b0;

    // Reset part-way through a refill
    a = 32'h0000_3A50;
    txn_id++;
    core_we = 1'b0; core_addr = a; core_req = 1'b1;
    wait_n = 0;
    while (beats < 7 && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    chk("rst_mid_reached_beat7", 64'(beats >= 7), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mid_core_done", 64'(core_done), 64'd0);
    chk("rst_mid_l1_mode", 64'(l1_mode), 64'd1);
    core_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bd_idx = a[10:4]; bd_inv = 1'b1;
    @(negedge clk);
    bd_inv = 1'b0;
    ref_vld[a[10:4]] = 1'b0;
    ref_hits = 0; ref_misses = 0; last_rdata = '0;
    run_txn(1'b0, a, 64'h0, "after_rst");

    for (int n = 0; n < 40; n++) begin
      a = {18'h0, 3'($urandom_range(0, 1)), idx_pool[$urandom_range(0, 3)],
           4'($urandom_range(0, 15))};
      gap_mode = ($urandom_range(0, 3) == 0);
      run_txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, "rnd");
    end
    gap_mode = 1'b0;

`ifdef L1_MISS_CTRL_STATS_EN
    chk("final_hit_cnt", 64'(hit_cnt), 64'(ref_hits));
    chk("final_miss_cnt", 64'(miss_cnt), 64'(ref_misses));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
